l2_mem_bridge: RTL

//  Sits directly downstream of the L2 cache, between it and main memory.

---
 rtl/l2_mem_bridge_pkg.sv | 19 +
 rtl/l2_mem_bridge.sv | 106 ++++++++++
 2 files changed

// File: rtl/l2_mem_bridge_pkg.sv
// Shared constants and state encoding for the L2 <-> memory line bridge.
package l2_mem_bridge_pkg;

  localparam int L2_LINE_W     = 512;
  localparam int L2_BEAT_W     = 128;
  localparam int L2_MEM_ADDR_W = 26;

  // Request direction as driven on mem_rw
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    MB_IDLE = 2'd0,
    MB_WR   = 2'd1,
    MB_RD   = 2'd2,
    MB_DONE = 2'd3
  } mb_state_e;

endpackage

// File: rtl/l2_mem_bridge.sv
// Splits one L2 line transfer into BEATS memory-bus beats; reads are
// reassembled into a full line and published on mem_rd at completion.
module l2_mem_bridge
  import l2_mem_bridge_pkg::*;
#(
  parameter int LINE_W = L2_LINE_W,
  parameter int BEAT_W = L2_BEAT_W,
  parameter int ADDR_W = L2_MEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_rw,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [LINE_W-1:0]     mem_wd,
  output logic [LINE_W-1:0]     mem_rd,
  output logic                  mem_complete,
  output logic                  mem_busy,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W+1:0]     bus_addr,
  output logic [BEAT_W-1:0]     bus_wd,
  input  logic                  bus_ack,
  input  logic [BEAT_W-1:0]     bus_rd
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = 2;

  mb_state_e               state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [ADDR_W-1:0]       addr_q;
  logic [LINE_W-1:0]       line_q;
  logic [LINE_W-1:0]       rd_buf;
  logic [LINE_W-1:0]       rd_next;

  // Read buffer with the current beat merged in, so the last beat can be
  // published to mem_rd in the same edge it is accepted.
  always_comb begin
    cnt_nxt = beat_cnt + 1'b1;
    rd_next = rd_buf;
    rd_next[int'(beat_cnt) * BEAT_W +: BEAT_W] = bus_rd;
  end

  // Line transfer FSM; every bus/L2 output is registered here, so bus_ack
  // never reaches bus_req combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= MB_IDLE;
      beat_cnt     <= '0;
      addr_q       <= '0;
      line_q       <= '0;
      rd_buf       <= '0;
      mem_rd       <= '0;
      mem_complete <= 1'b0;
      mem_busy     <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wd       <= '0;
    end else begin
      mem_complete <= 1'b0;
      case (state)
        MB_IDLE: begin
          if (mem_req) begin
            addr_q   <= mem_addr;
            line_q   <= mem_wd;
            beat_cnt <= '0;
            state    <= (mem_rw == MEM_WRITE) ? MB_WR : MB_RD;
            mem_busy <= 1'b1;
            bus_req  <= 1'b1;
            bus_we   <= mem_rw;
            bus_addr <= {mem_addr, {CNT_W{1'b0}}};
            bus_wd   <= mem_wd[BEAT_W-1:0];
          end
        end
        MB_WR, MB_RD: begin
          // Beat signals are held until memory accepts the beat
          if (bus_ack) begin
            if (state == MB_RD) rd_buf <= rd_next;
            if (beat_cnt == CNT_W'(BEATS-1)) begin
              beat_cnt     <= '0;
              bus_req      <= 1'b0;
              bus_we       <= 1'b0;
              state        <= MB_DONE;
              mem_complete <= 1'b1;
              if (state == MB_RD) mem_rd <= rd_next;
            end else begin
              beat_cnt <= cnt_nxt;
              bus_addr <= {addr_q, cnt_nxt};
              bus_wd   <= line_q[int'(cnt_nxt) * BEAT_W +: BEAT_W];
            end
          end
        end
        MB_DONE: begin
          // Requests seen here are dropped; L2 must re-request after completion
          state    <= MB_IDLE;
          mem_busy <= 1'b0;
        end
        default: state <= MB_IDLE;
      endcase
    end
  end

endmodule
